// File: rtl/hist_pkg.sv
// Shared definitions for the pulse-histogram host readout path.
package hist_pkg;

   localparam int         NIPI_DEF = 64;
   localparam logic [7:0] HDR_DEF  = 8'hA5;

   localparam logic [7:0] CMD_RD_CH      = 8'h01;
   localparam logic [7:0] CMD_RD_IPI     = 8'h02;
   localparam logic [7:0] CMD_RD_IPI_CLR = 8'h03;
   localparam logic [7:0] CMD_CLR        = 8'h04;

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_HDR  = 4'd1,
      S_CMD  = 4'd2,
      S_LEN  = 4'd3,
      S_LOAD = 4'd4,
      S_B0   = 4'd5,
      S_B1   = 4'd6,
      S_B2   = 4'd7,
      S_B3   = 4'd8,
      S_CSUM = 4'd9,
      S_CLR  = 4'd10
   } state_e;

   function automatic logic [7:0] csum_upd(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

endpackage

// File: rtl/byte_tx_reg.sv
// Holding register for one outbound host-link byte with valid/ready handshake.
module byte_tx_reg (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       load_i,
   input  logic [7:0] data_i,
   input  logic       tx_ready_i,
   output logic [7:0] tx_data_o,
   output logic       tx_valid_o
);

   logic [7:0] data_q;
   logic       valid_q;

   // Capture a byte on load; drop valid once the link has taken it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q  <= 8'h00;
         valid_q <= 1'b0;
      end else if (load_i) begin
         data_q  <= data_i;
         valid_q <= 1'b1;
      end else if (valid_q && tx_ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign tx_data_o  = data_q;
   assign tx_valid_o = valid_q;

endmodule

// File: rtl/hist_readout.sv
// Command-driven framed readout of histogram counts and IPI bins, plus the
// histogram clear pulse and its settle window.
module hist_readout
   import hist_pkg::*;
#(
   parameter int         NIPI    = NIPI_DEF,
   parameter logic [7:0] HDR     = HDR_DEF,
   parameter int         CLRWAIT = NIPI + 4
) (
   input  logic        clkin,
   input  logic        resetn,
   input  logic        cmd_valid,
   input  logic [7:0]  cmd_data,
   input  logic [31:0] histo   [2],
   input  logic [31:0] ipihist [NIPI],
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        resethist,
   output logic        busy,
   output logic        cmd_err
);

   localparam logic [7:0] NIPI_B     = 8'(NIPI);
   localparam logic [8:0] CLRWAIT_W  = 9'(CLRWAIT);

   state_e      state_q;
   logic [7:0]  cmd_q;
   logic [7:0]  n_q;
   logic [7:0]  index_q;
   logic [31:0] word_q;
   logic [7:0]  csum_q;
   logic [8:0]  wait_q;
   logic        loaded_q;
   logic        resethist_q;
   logic        busy_q;
   logic        cmd_err_q;

   logic [7:0]  byte_s;
   logic        is_tx_s;
   logic        load_s;
   logic        sent_s;
   logic [31:0] live_word_s;

   // Byte presented by the current transmit state.
   always_comb begin
      byte_s  = 8'h00;
      is_tx_s = 1'b1;
      case (state_q)
         S_HDR:                    byte_s = HDR;
         S_CMD:                    byte_s = cmd_q;
         S_LEN:                    byte_s = n_q;
         S_B0, S_B1, S_B2, S_B3:   byte_s = word_q[7:0];
         S_CSUM:                   byte_s = csum_q;
         default:                  is_tx_s = 1'b0;
      endcase
   end

   // Word selected by index, sampled live so each bin reflects its own LOAD cycle.
   always_comb begin
      live_word_s = 32'h0000_0000;
      if (cmd_q == CMD_RD_CH) begin
         live_word_s = histo[index_q[0]];
      end else begin
         for (int i = 0; i < NIPI; i++) begin
            live_word_s = (index_q == 8'(i)) ? ipihist[i] : live_word_s;
         end
      end
   end

   assign load_s = is_tx_s && !loaded_q;
   assign sent_s = loaded_q && tx_valid && tx_ready;

   // Readout/clear sequencer with registered status outputs.
   always_ff @(posedge clkin or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         cmd_q       <= 8'h00;
         n_q         <= 8'h00;
         index_q     <= 8'h00;
         word_q      <= 32'h0000_0000;
         csum_q      <= 8'h00;
         wait_q      <= 9'd0;
         loaded_q    <= 1'b0;
         resethist_q <= 1'b0;
         busy_q      <= 1'b0;
         cmd_err_q   <= 1'b0;
      end else begin
         cmd_err_q   <= 1'b0;
         resethist_q <= 1'b0;
         if (cmd_valid && state_q != S_IDLE) cmd_err_q <= 1'b1;
         if (load_s) begin
            loaded_q <= 1'b1;
            if (state_q != S_CSUM) csum_q <= csum_upd(csum_q, byte_s);
         end
         if (sent_s) loaded_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (cmd_valid) begin
                  cmd_q    <= cmd_data;
                  index_q  <= 8'h00;
                  csum_q   <= 8'h00;
                  loaded_q <= 1'b0;
                  case (cmd_data)
                     CMD_RD_CH: begin
                        n_q     <= 8'd2;
                        state_q <= S_HDR;
                        busy_q  <= 1'b1;
                     end
                     CMD_RD_IPI, CMD_RD_IPI_CLR: begin
                        n_q     <= NIPI_B;
                        state_q <= S_HDR;
                        busy_q  <= 1'b1;
                     end
                     CMD_CLR: begin
                        state_q     <= S_CLR;
                        resethist_q <= 1'b1;
                        wait_q      <= 9'd0;
                        busy_q      <= 1'b1;
                     end
                     default: cmd_err_q <= 1'b1;
                  endcase
               end
            end
            S_HDR: if (sent_s) state_q <= S_CMD;
            S_CMD: if (sent_s) state_q <= S_LEN;
            S_LEN: if (sent_s) state_q <= S_LOAD;
            S_LOAD: begin
               word_q  <= live_word_s;
               state_q <= S_B0;
            end
            S_B0, S_B1, S_B2: begin
               if (sent_s) begin
                  word_q  <= {8'h00, word_q[31:8]};
                  state_q <= state_e'(state_q + 4'd1);
               end
            end
            S_B3: begin
               if (sent_s) begin
                  if (index_q == n_q - 8'd1) begin
                     state_q <= S_CSUM;
                  end else begin
                     index_q <= index_q + 8'd1;
                     state_q <= S_LOAD;
                  end
               end
            end
            S_CSUM: begin
               if (sent_s) begin
                  if (cmd_q == CMD_RD_IPI_CLR) begin
                     state_q     <= S_CLR;
                     resethist_q <= 1'b1;
                     wait_q      <= 9'd0;
                  end else begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end
               end
            end
            S_CLR: begin
               if (wait_q == CLRWAIT_W) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  wait_q <= wait_q + 9'd1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   byte_tx_reg u_tx (
      .clk_i      (clkin),
      .rst_ni     (resetn),
      .load_i     (load_s),
      .data_i     (byte_s),
      .tx_ready_i (tx_ready),
      .tx_data_o  (tx_data),
      .tx_valid_o (tx_valid)
   );

   assign resethist = resethist_q;
   assign busy      = busy_q;
   assign cmd_err   = cmd_err_q;

endmodule
